lf_gain_scheduler: RTL and testbench
====================================

LF_GAIN_SCHEDULER -- requirements
Module: lf_gain_scheduler

Interface
REQ-001 Parameter WIN_LEN, default 16: phase-detector samples per evaluation window (range 4..64).
REQ-002 Parameter TOG_TH, default 10: minimum toggles per window needed to step down one gain level.
REQ-003 Parameter RUN_MAX, default 8: consecutive identical samples that declare loss of lock.
REQ-004 Parameter LOCK_WINS, default 4: consecutive qualifying windows in FINE needed to declare lock.
REQ-005 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-006 Port reset  input  1: asynchronous, active-low reset (low = reset asserted).
REQ-007 Port enable  input  1: high = run acquisition; low = return to IDLE.
REQ-008 Port pd_valid  input  1: one-cycle strobe qualifying early.
REQ-009 Port early  input  1: bang-bang phase detector decision; 1 = early, 0 = late.
REQ-010 Port overflow, underflow  input  1 each: integral-path saturation flags from the loop filter.
REQ-011 Port OverflowP, UnderflowP  input  1 each: proportional-path saturation flags from the loop filter.
REQ-012 Port sel  output  2: loop-filter gain select; registered.
REQ-013 Port state  output  3: current state code; registered.
REQ-014 Port locked  output  1: high only in LOCKED; registered.
REQ-015 Port lf_clear  output  1: one-cycle pulse requesting a loop-filter integrator clear; registered.

Function
REQ-016 States and codes: IDLE=0, COARSE=1, MEDIUM=2, FINE=3, LOCKED=4; the sel values are IDLE 2'b00, COARSE 2'b11, MEDIUM 2'b10, FINE 2'b01, LOCKED 2'b01.
REQ-017 sel, state and locked SHALL reflect the current state in the same cycle the state register updates, with no extra latency.
REQ-018 IDLE -> COARSE on the first clock with enable=1, and lf_clear SHALL pulse for that cycle.
REQ-019 enable=0 in any state -> IDLE on the next edge, with all counters and the previous-sample register cleared.
REQ-020 Sample counter SHALL count pd_valid strobes from 0 to WIN_LEN-1; the strobe at count WIN_LEN-1 ends the window.
REQ-021 A toggle SHALL be counted on a pd_valid strobe whose early differs from the previous valid sample; the first sample after state entry or clear SHALL NOT count.
REQ-022 Window evaluation SHALL include the final sample's toggle, after which the sample and toggle counters clear on the same edge.
REQ-023 At window end, toggles >= TOG_TH in COARSE -> MEDIUM and in MEDIUM -> FINE; otherwise stay in the current state.
REQ-024 In FINE, a qualifying window SHALL increment a lock counter and a non-qualifying window SHALL clear it; when the lock counter reaches LOCK_WINS the state SHALL go to LOCKED.
REQ-025 Run counter SHALL count consecutive identical valid samples, saturating at RUN_MAX, and SHALL reset to 1 on a toggle.
REQ-026 In LOCKED, run counter = RUN_MAX -> MEDIUM; the state SHALL NOT change at window end while LOCKED.
REQ-027 Any saturation flag high in COARSE, MEDIUM, FINE or LOCKED -> COARSE, with all counters cleared and lf_clear pulsed for one cycle.
REQ-028 Priority SHALL be: enable=0, then saturation, then run-length loss, then window evaluation.
REQ-029 Every state change SHALL clear the sample, toggle and run counters; the lock counter SHALL clear on any exit from FINE.
REQ-030 Counters SHALL be sized to hold WIN_LEN, RUN_MAX and LOCK_WINS without wrap-around.

Reset
REQ-031 On reset low: state=IDLE, sel=2'b00, locked=0, lf_clear=0, all counters and the previous-sample register = 0, applied immediately without waiting for clk.
REQ-032 Reset asserted mid-acquisition SHALL abort to IDLE, and no lf_clear pulse SHALL be produced during reset.

Structure
REQ-033 The state codes and sel encodings SHALL be defined in a shared loop-filter package.
REQ-034 A sub-module lf_toggle_window SHALL hold the sample, toggle and run counters; the FSM SHALL stay in the top module.

Verification
REQ-035 Enable=1, pd_valid every cycle, early alternating -> COARSE, MEDIUM and FINE after 16 strobes each, then LOCKED after 4 more windows; locked=1 with sel=2'b01.
REQ-036 In COARSE, 16 samples with only 9 toggles -> state stays COARSE, sel=2'b11.
REQ-037 In LOCKED, early held at 1 for 8 strobes -> MEDIUM, locked=0, sel=2'b10.
REQ-038 In FINE, overflow=1 for one cycle coinciding with window end -> COARSE, lf_clear high for exactly one cycle.
REQ-039 In FINE, windows qualifying, qualifying, not qualifying, then 4 qualifying -> LOCKED only after the seventh window.
REQ-040 Reset driven low mid-FINE between clock edges -> outputs at their reset values before the next edge; enable=0 -> IDLE on the next edge.

Source files
------------

// File: rtl/lf_gain_scheduler_pkg.sv
// Shared loop-filter definitions: scheduler state codes and gain-select encodings.
package lf_gain_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_COARSE = 3'd1,
    ST_MEDIUM = 3'd2,
    ST_FINE   = 3'd3,
    ST_LOCKED = 3'd4
  } lf_state_e;

  localparam logic [1:0] SEL_IDLE   = 2'b00;
  localparam logic [1:0] SEL_COARSE = 2'b11;
  localparam logic [1:0] SEL_MEDIUM = 2'b10;
  localparam logic [1:0] SEL_FINE   = 2'b01;
  localparam logic [1:0] SEL_LOCKED = 2'b01;

  function automatic logic [1:0] sel_for(input lf_state_e s);
    case (s)
      ST_COARSE: sel_for = SEL_COARSE;
      ST_MEDIUM: sel_for = SEL_MEDIUM;
      ST_FINE:   sel_for = SEL_FINE;
      ST_LOCKED: sel_for = SEL_LOCKED;
      default:   sel_for = SEL_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/lf_gain_scheduler_toggle_window.sv
// lf_toggle_window: per-window sample/toggle counting and run-length tracking of
// phase-detector decisions. Results include the sample strobed this cycle.
module lf_toggle_window #(
  parameter int unsigned WIN_LEN = 16,
  parameter int unsigned RUN_MAX = 8,
  localparam int unsigned CW = $clog2(WIN_LEN + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          pd_valid,
  input  logic          early,
  output logic          win_end,
  output logic [CW-1:0] tog_total,
  output logic          run_hit
);

  localparam int unsigned RW = $clog2(RUN_MAX + 1);

  logic [CW-1:0] smp_q, smp_d, tog_q, tog_d;
  logic [RW-1:0] run_q, run_d, run_nx;
  logic          prev_q, prev_d, have_q, have_d;
  logic          is_tog;

  always_comb begin
    is_tog    = pd_valid && have_q && (early != prev_q);
    tog_total = tog_q + CW'(is_tog);
    win_end   = pd_valid && (smp_q == CW'(WIN_LEN - 1));
    if (!have_q || is_tog)            run_nx = RW'(1);
    else if (run_q == RW'(RUN_MAX))   run_nx = run_q;
    else                              run_nx = run_q + RW'(1);
    run_hit = pd_valid && (run_nx == RW'(RUN_MAX));

    smp_d  = smp_q;
    tog_d  = tog_q;
    run_d  = run_q;
    prev_d = prev_q;
    have_d = have_q;
    if (clr) begin
      smp_d  = '0;
      tog_d  = '0;
      run_d  = '0;
      prev_d = 1'b0;
      have_d = 1'b0;
    end else if (pd_valid) begin
      // Window rollover keeps the previous sample, so a toggle across the boundary counts.
      prev_d = early;
      have_d = 1'b1;
      run_d  = run_nx;
      if (win_end) begin
        smp_d = '0;
        tog_d = '0;
      end else begin
        smp_d = smp_q + CW'(1);
        tog_d = tog_total;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      smp_q  <= '0;
      tog_q  <= '0;
      run_q  <= '0;
      prev_q <= 1'b0;
      have_q <= 1'b0;
    end else begin
      smp_q  <= smp_d;
      tog_q  <= tog_d;
      run_q  <= run_d;
      prev_q <= prev_d;
      have_q <= have_d;
    end
  end

endmodule

// File: rtl/lf_gain_scheduler.sv
// Loop-filter gain scheduler: steps gain down COARSE->MEDIUM->FINE on toggle-rich
// windows, declares lock after consecutive good FINE windows, falls back on loss.
module lf_gain_scheduler
  import lf_gain_scheduler_pkg::*;
#(
  parameter int unsigned WIN_LEN   = 16,
  parameter int unsigned TOG_TH    = 10,
  parameter int unsigned RUN_MAX   = 8,
  parameter int unsigned LOCK_WINS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       pd_valid,
  input  logic       early,
  input  logic       overflow,
  input  logic       underflow,
  input  logic       OverflowP,
  input  logic       UnderflowP,
  output logic [1:0] sel,
  output logic [2:0] state,
  output logic       locked,
  output logic       lf_clear
);

  localparam int unsigned CW = $clog2(WIN_LEN + 1);
  localparam int unsigned LW = $clog2(LOCK_WINS + 1);

  lf_state_e     state_q, state_d;
  logic [1:0]    sel_q, sel_d;
  logic          locked_q, locked_d, lf_clear_q, lf_clear_d;
  logic [LW-1:0] lock_q, lock_d;
  logic          sat, sat_clr, win_clr, win_end, run_hit, qual;
  logic [CW-1:0] tog_total;

  lf_toggle_window #(
    .WIN_LEN(WIN_LEN),
    .RUN_MAX(RUN_MAX)
  ) u_win (
    .clk      (clk),
    .reset    (reset),
    .clr      (win_clr),
    .pd_valid (pd_valid),
    .early    (early),
    .win_end  (win_end),
    .tog_total(tog_total),
    .run_hit  (run_hit)
  );

  always_comb begin
    state_d    = state_q;
    lock_d     = lock_q;
    lf_clear_d = 1'b0;
    sat_clr    = 1'b0;
    sat        = overflow | underflow | OverflowP | UnderflowP;
    qual       = 32'(tog_total) >= TOG_TH;

    if (!enable) begin
      state_d = ST_IDLE;
    end else if (state_q == ST_IDLE) begin
      state_d    = ST_COARSE;
      lf_clear_d = 1'b1;
    end else if (sat) begin
      state_d    = ST_COARSE;
      lf_clear_d = 1'b1;
      sat_clr    = 1'b1;
    end else if (state_q == ST_LOCKED) begin
      if (run_hit) state_d = ST_MEDIUM;
    end else if (win_end) begin
      case (state_q)
        ST_COARSE: if (qual) state_d = ST_MEDIUM;
        ST_MEDIUM: if (qual) state_d = ST_FINE;
        ST_FINE: begin
          if (!qual)                              lock_d = '0;
          else if (lock_q == LW'(LOCK_WINS - 1))  state_d = ST_LOCKED;
          else                                    lock_d = lock_q + LW'(1);
        end
        default: ;
      endcase
    end

    if (state_d != ST_FINE) lock_d = '0;
    win_clr  = !enable || sat_clr || (state_d != state_q);
    sel_d    = sel_for(state_d);
    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      sel_q      <= SEL_IDLE;
      locked_q   <= 1'b0;
      lf_clear_q <= 1'b0;
      lock_q     <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      locked_q   <= locked_d;
      lf_clear_q <= lf_clear_d;
      lock_q     <= lock_d;
    end
  end

  assign state    = state_q;
  assign sel      = sel_q;
  assign locked   = locked_q;
  assign lf_clear = lf_clear_q;

endmodule

// File: tb/tb_lf_gain_scheduler.sv
// Randomized and directed bench for lf_gain_scheduler against a history-based reference model.
module tb_lf_gain_scheduler;

  localparam int WL  = 16;
  localparam int TT  = 10;
  localparam int RM  = 8;
  localparam int LWN = 4;

  logic       clk = 1'b0;
  logic       reset, enable, pd_valid, early;
  logic       overflow, underflow, OverflowP, UnderflowP;
  logic [1:0] sel;
  logic [2:0] state;
  logic       locked, lf_clear;

  always #5 clk = ~clk;

  lf_gain_scheduler #(
    .WIN_LEN(WL),
    .TOG_TH(TT),
    .RUN_MAX(RM),
    .LOCK_WINS(LWN)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .pd_valid(pd_valid), .early(early),
    .overflow(overflow), .underflow(underflow), .OverflowP(OverflowP), .UnderflowP(UnderflowP),
    .sel(sel), .state(state), .locked(locked), .lf_clear(lf_clear)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: state number, lock window count, lf_clear expectation and the
  // list of samples seen since the last clear.
  int m_st   = 0;
  int m_lock = 0;
  bit m_lfclr = 1'b0;
  bit hist[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
    end
  endtask

  function automatic int exp_sel(input int s);
    case (s)
      1: return 3;
      2: return 2;
      3: return 1;
      4: return 1;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_st = 0; m_lock = 0; m_lfclr = 1'b0; hist.delete();
  endtask

  task automatic model_step();
    int nxt, n, run, tog;
    if (!reset) begin
      model_reset();
      return;
    end
    nxt = m_st;
    m_lfclr = 1'b0;
    if (!enable) nxt = 0;
    else if (m_st == 0) begin nxt = 1; m_lfclr = 1'b1; end
    else if (overflow | underflow | OverflowP | UnderflowP) begin
      nxt = 1; m_lfclr = 1'b1; hist.delete();
    end else if (pd_valid) begin
      hist.push_back(early);
      n = hist.size();
      run = 0;
      for (int j = n - 1; j >= 0 && run < RM; j--) begin
        if (hist[j] != early) break;
        run++;
      end
      if (m_st == 4) begin
        if (run >= RM) nxt = 2;
      end else if (n % WL == 0) begin
        tog = 0;
        for (int j = n - WL; j < n; j++)
          if (j > 0 && hist[j] != hist[j-1]) tog++;
        if (m_st == 1 && tog >= TT) nxt = 2;
        else if (m_st == 2 && tog >= TT) nxt = 3;
        else if (m_st == 3) begin
          if (tog >= TT) begin
            m_lock++;
            if (m_lock == LWN) nxt = 4;
          end else m_lock = 0;
        end
      end
    end
    if (nxt != m_st || !enable) hist.delete();
    if (nxt != 3) m_lock = 0;
    m_st = nxt;
  endtask

  task automatic compare_outputs(input string pfx);
    check({pfx, "_state"},    32'(state),    32'(m_st));
    check({pfx, "_sel"},      32'(sel),      32'(exp_sel(m_st)));
    check({pfx, "_locked"},   32'(locked),   32'(m_st == 4));
    check({pfx, "_lf_clear"}, 32'(lf_clear), 32'(m_lfclr));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    compare_outputs("cyc");
  endtask

  task automatic drive(input logic en, input logic v, input logic e, input logic [3:0] s);
    enable = en; pd_valid = v; early = e;
    {overflow, underflow, OverflowP, UnderflowP} = s;
    cyc();
  endtask

  task automatic do_reset();
    @(negedge clk);
    enable = 1'b0; pd_valid = 1'b0; early = 1'b0;
    {overflow, underflow, OverflowP, UnderflowP} = 4'b0;
    #2 reset = 1'b0;
    model_reset();
    #1 compare_outputs("rst");
    cyc();
    reset = 1'b1;
  endtask

  task automatic to_fine();
    logic e;
    e = 1'b0;
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 4'b0);
    for (int i = 0; i < 2 * WL; i++) begin
      drive(1'b1, 1'b1, e, 4'b0);
      e = ~e;
    end
    check("to_fine_state", 32'(state), 32'd3);
  endtask

  initial begin
    logic e;
    int p;
    reset = 1'b1; enable = 1'b0; pd_valid = 1'b0; early = 1'b0;
    {overflow, underflow, OverflowP, UnderflowP} = 4'b0;

    // Reset values
    do_reset();
    check("reset_state", 32'(state), 32'd0);
    check("reset_sel",   32'(sel),   32'd0);

    // Full acquisition with alternating decisions
    drive(1'b1, 1'b0, 1'b0, 4'b0);
    check("enable_lf_clear", 32'(lf_clear), 32'd1);
    check("enable_coarse",   32'(state),    32'd1);
    e = 1'b0;
    for (int i = 0; i < 6 * WL; i++) begin
      drive(1'b1, 1'b1, e, 4'b0);
      e = ~e;
      if (i == WL - 2)     check("coarse_before_win", 32'(state), 32'd1);
      if (i == WL - 1)     check("medium_after_16",   32'(state), 32'd2);
      if (i == 2 * WL - 1) check("fine_after_32",     32'(state), 32'd3);
      if (i == 6 * WL - 2) check("fine_before_lock",  32'(state), 32'd3);
    end
    check("acq_locked", 32'(locked), 32'd1);
    check("acq_sel",    32'(sel),    32'd1);

    // Run-length loss in LOCKED
    for (int i = 0; i < RM; i++) drive(1'b1, 1'b1, 1'b1, 4'b0);
    check("runloss_state",  32'(state),  32'd2);
    check("runloss_locked", 32'(locked), 32'd0);
    check("runloss_sel",    32'(sel),    32'd2);

    // COARSE window with only 9 toggles
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 4'b0);
    for (int i = 0; i < WL; i++)
      drive(1'b1, 1'b1, (i == 0) ? 1'b0 : ((i <= 9) ? 1'(i % 2) : 1'b1), 4'b0);
    check("nine_tog_state", 32'(state), 32'd1);
    check("nine_tog_sel",   32'(sel),   32'd3);

    // FINE lock counter: q, q, nq, q, q, q, q
    to_fine();
    for (int w = 0; w < 7; w++) begin
      for (int i = 0; i < WL; i++) begin
        drive(1'b1, 1'b1, (w == 2) ? 1'b1 : e, 4'b0);
        e = ~e;
      end
      check($sformatf("lockseq_w%0d", w), 32'(state), (w == 6) ? 32'd4 : 32'd3);
    end

    // Saturation coinciding with window end in FINE
    to_fine();
    for (int i = 0; i < WL - 1; i++) begin
      drive(1'b1, 1'b1, e, 4'b0);
      e = ~e;
    end
    drive(1'b1, 1'b1, e, 4'b1000);
    check("sat_state",    32'(state),    32'd1);
    check("sat_lf_clear", 32'(lf_clear), 32'd1);
    drive(1'b1, 1'b0, 1'b0, 4'b0);
    check("sat_lf_clear_off", 32'(lf_clear), 32'd0);

    // Asynchronous reset mid-FINE, then enable low
    to_fine();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, e, 4'b0);
      e = ~e;
    end
    @(negedge clk);
    #2 reset = 1'b0;
    model_reset();
    #1;
    check("async_rst_state",    32'(state),    32'd0);
    check("async_rst_sel",      32'(sel),      32'd0);
    check("async_rst_locked",   32'(locked),   32'd0);
    check("async_rst_lf_clear", 32'(lf_clear), 32'd0);
    drive(1'b1, 1'b1, 1'b1, 4'b0);
    check("in_rst_lf_clear", 32'(lf_clear), 32'd0);
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 4'b0);
    check("post_rst_idle", 32'(state), 32'd0);
    to_fine();
    drive(1'b0, 1'b1, 1'b1, 4'b0);
    check("disable_idle", 32'(state), 32'd0);

    // Randomized traffic checked every cycle against the model
    do_reset();
    p = 14;
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) p = $urandom_range(4, 16);
      if ($urandom_range(0, 15) < p) e = ~e;
      drive(($urandom_range(0, 299) != 0),
            ($urandom_range(0, 3) != 0),
            e,
            {($urandom_range(0, 499) == 0), ($urandom_range(0, 499) == 0),
             ($urandom_range(0, 499) == 0), ($urandom_range(0, 499) == 0)});
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
